// File: rtl/hs_arb_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hs_pkg
//  Purpose  : Shared types and round-robin pick helper for hs_arb_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
package hs_pkg;

  // Input-side arbiter states
  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_HOLD = 1'b1
  } hs_in_state_t;

  // Output-side handshake states
  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_RTZ  = 2'd2
  } hs_out_state_t;

  // Widest request vector the pick helper scans; N_CH must not exceed this.
  localparam int RR_MAX_CH = 32;

  // First asserted request at or after ptr, wrapping modulo n_ch.
  // Scanned from the far end so the smallest offset is the last to win.
  // With no request asserted the result is ptr; callers gate on |req.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] req,
                                 input int ptr, input int n_ch);
    int pick;
    int idx;
    pick = ptr;
    for (int i = RR_MAX_CH - 1; i >= 0; i--) begin
      if (i < n_ch) begin
        idx = ptr + i;
        if (idx >= n_ch) idx = idx - n_ch;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_arb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : hs_pipe_stage
//  Purpose  : One bundled-data pipeline register with its full flag.
//             A load wins over a clear so a stage can pass its word on and
//             accept the next one in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [PW-1:0] d,
  output logic          full,
  output logic [PW-1:0] q
);

  // Register the payload on load; drop the full flag when the word leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hs_arb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : hs_arb_pipe
//  Purpose  : N-channel 4-phase req/ack merge. A round-robin arbiter captures
//             one word at a time into a DEPTH-stage bundled-data pipeline
//             that drains through a single 4-phase output channel.
//  Options  : HS_ARB_PIPE_TAG_EN - carry the source channel index with each
//             word and expose it on tag_o.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_arb_pipe
  import hs_pkg::*;
#(
  parameter  int N_CH  = 2,
  parameter  int W     = 8,
  parameter  int DEPTH = 3,
  localparam int IDW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req_i,
  output logic [N_CH-1:0]   ack_i,
  input  logic [N_CH*W-1:0] dat_i,
  output logic              req_o,
  input  logic              ack_o,
  output logic [W-1:0]      dat_o
`ifdef HS_ARB_PIPE_TAG_EN
  ,
  output logic [IDW-1:0]    tag_o
`endif
);

`ifdef HS_ARB_PIPE_TAG_EN
  localparam int PW = W + IDW;
`else
  localparam int PW = W;
`endif

  hs_in_state_t  in_state;
  hs_out_state_t out_state;

  logic [IDW-1:0] ptr;       // round-robin start point
  logic [IDW-1:0] gnt;       // channel currently held by the arbiter
  logic [IDW-1:0] pick;
  logic [W-1:0]   pick_dat;
  logic           grant;
  logic           gnt_req;   // request line of the held channel
  logic           out_take;  // consumer acknowledged the presented word

  logic [DEPTH-1:0] full;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] leave;
  logic [PW-1:0]    stg_d [DEPTH];
  logic [PW-1:0]    stg_q [DEPTH];

  // Round-robin choice and the data of the chosen channel
  always_comb begin
    pick     = IDW'(rr_pick(RR_MAX_CH'(req_i), int'(ptr), N_CH));
    pick_dat = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (IDW'(i) == pick) pick_dat = dat_i[i*W +: W];
    end
  end

  // A new grant needs an idle arbiter, a requester and an empty first stage;
  // ack_i is one-hot on the held channel, so it selects that channel's req.
  assign grant    = (in_state == IN_IDLE) && (|req_i) && !full[0];
  assign gnt_req  = |(req_i & ack_i);
  assign out_take = (out_state == OUT_REQ) && ack_o;

  // Arbiter FSM: grant, hold ack until the sender returns to zero, advance ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state <= IN_IDLE;
      ack_i    <= '0;
      ptr      <= '0;
      gnt      <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (grant) begin
            gnt <= pick;
            for (int i = 0; i < N_CH; i++) ack_i[i] <= (IDW'(i) == pick);
            in_state <= IN_HOLD;
          end
        end
        IN_HOLD: begin
          if (!gnt_req) begin
            ack_i    <= '0;
            ptr      <= (gnt == IDW'(N_CH - 1)) ? '0 : gnt + IDW'(1);
            in_state <= IN_IDLE;
          end
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  // Which stages hand their word on this cycle: the last stage leaves on the
  // consumer's ack, any other stage when the next one is empty or leaving.
  always_comb begin : p_leave
    logic lv;
    lv               = out_take;
    leave            = '0;
    leave[DEPTH-1]   = lv;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      lv       = full[k] & (~full[k+1] | lv);
      leave[k] = lv;
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign load[k] = grant;
`ifdef HS_ARB_PIPE_TAG_EN
        assign stg_d[k] = {pick, pick_dat};
`else
        assign stg_d[k] = pick_dat;
`endif
      end else begin : g_body
        assign load[k]  = leave[k-1];
        assign stg_d[k] = stg_q[k-1];
      end

      hs_pipe_stage #(.PW(PW)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .load  (load[k]),
        .clear (leave[k]),
        .d     (stg_d[k]),
        .full  (full[k]),
        .q     (stg_q[k])
      );
    end
  endgenerate

  // Output FSM: present the last stage, free it on ack, wait for ack to drop
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      req_o     <= 1'b0;
      dat_o     <= '0;
`ifdef HS_ARB_PIPE_TAG_EN
      tag_o     <= '0;
`endif
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (full[DEPTH-1]) begin
            dat_o     <= stg_q[DEPTH-1][W-1:0];
`ifdef HS_ARB_PIPE_TAG_EN
            tag_o     <= stg_q[DEPTH-1][PW-1:W];
`endif
            req_o     <= 1'b1;
            out_state <= OUT_REQ;
          end
        end
        OUT_REQ: begin
          if (ack_o) begin
            req_o     <= 1'b0;
            out_state <= OUT_RTZ;
          end
        end
        OUT_RTZ: begin
          if (!ack_o) out_state <= OUT_IDLE;
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_arb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_arb_pipe
//  Purpose  : Directed self-checking bench for hs_arb_pipe (2- and 4-channel
//             instances). Inputs change 1-3 ns after posedge, outputs are
//             read 3-4 ns after posedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_arb_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-channel instance
  logic [1:0]  req2, ack2;
  logic [15:0] dat2;
  logic        reqo2, acko2;
  logic [7:0]  dato2;
  // 4-channel instance
  logic [3:0]  req4, ack4;
  logic [31:0] dat4;
  logic        reqo4, acko4;
  logic [7:0]  dato4;
`ifdef HS_ARB_PIPE_TAG_EN
  logic [0:0]  tago2;
  logic [1:0]  tago4;
  logic [1:0]  obs4t [$];
`endif

  int compares;
  int fails;
  logic cons_en;

  logic [7:0] pq0 [$];
  logic [7:0] pq1 [$];
  int         cnt4 [4];

  logic [7:0] obs2 [$];
  int         gnt2 [$];
  logic [7:0] obs4 [$];
  logic       prev_r2, prev_r4;
  logic [1:0] prev_a2;

  hs_arb_pipe #(.N_CH(2), .W(8), .DEPTH(3)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .req_i (req2),
    .ack_i (ack2),
    .dat_i (dat2),
    .req_o (reqo2),
    .ack_o (acko2),
    .dat_o (dato2)
`ifdef HS_ARB_PIPE_TAG_EN
    ,
    .tag_o (tago2)
`endif
  );

  hs_arb_pipe #(.N_CH(4), .W(8), .DEPTH(3)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .req_i (req4),
    .ack_i (ack4),
    .dat_i (dat4),
    .req_o (reqo4),
    .ack_o (acko4),
    .dat_o (dato4)
`ifdef HS_ARB_PIPE_TAG_EN
    ,
    .tag_o (tago4)
`endif
  );

  // 4-phase senders: raise req with the next queued word, drop it on ack
  initial begin : p_src
    forever begin
      @(posedge clk); #2;
      if (req2[0] && ack2[0]) req2[0] = 1'b0;
      else if (!req2[0] && !ack2[0] && pq0.size() > 0) begin
        dat2[7:0] = pq0.pop_front(); req2[0] = 1'b1;
      end
      if (req2[1] && ack2[1]) req2[1] = 1'b0;
      else if (!req2[1] && !ack2[1] && pq1.size() > 0) begin
        dat2[15:8] = pq1.pop_front(); req2[1] = 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
        if (req4[c] && ack4[c]) req4[c] = 1'b0;
        else if (!req4[c] && !ack4[c] && cnt4[c] > 0) begin
          dat4[c*8 +: 8] = 8'(c); req4[c] = 1'b1; cnt4[c] = cnt4[c] - 1;
        end
      end
    end
  end

  // Consumers: ack follows req one cycle later (2-ch one can be stalled)
  initial begin : p_snk
    forever begin
      @(posedge clk); #2;
      acko2 = cons_en ? reqo2 : 1'b0;
      acko4 = reqo4;
    end
  end

  // Log presented words and grant order; logs restart at reset
  initial begin : p_mon
    forever begin
      @(posedge clk); #4;
      if (rst) begin
        obs2.delete(); gnt2.delete(); obs4.delete();
`ifdef HS_ARB_PIPE_TAG_EN
        obs4t.delete();
`endif
        prev_r2 = 1'b0; prev_r4 = 1'b0; prev_a2 = 2'b00;
      end else begin
        if (reqo2 && !prev_r2) obs2.push_back(dato2);
        if (reqo4 && !prev_r4) begin
          obs4.push_back(dato4);
`ifdef HS_ARB_PIPE_TAG_EN
          obs4t.push_back(tago4);
`endif
        end
        for (int c = 0; c < 2; c++) if (ack2[c] && !prev_a2[c]) gnt2.push_back(c);
        prev_r2 = reqo2; prev_r4 = reqo4; prev_a2 = ack2;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_obs2(input int n, input int lim);
    int t = 0;
    while (obs2.size() < n && t < lim) begin tick(); t++; end
    check("wait_obs2", 32'(obs2.size() >= n), 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin : p_main
    logic [7:0] held;
    compares = 0; fails = 0;
    rst = 1'b1; cons_en = 1'b1;
    req2 = '0; dat2 = '0; acko2 = 1'b0;
    req4 = '0; dat4 = '0; acko4 = 1'b0;
    for (int c = 0; c < 4; c++) cnt4[c] = 0;
    repeat (3) tick();

    // Reset state
    check("rst_ack_i", 32'(ack2), 32'h0);
    check("rst_req_o", 32'(reqo2), 32'h0);
    check("rst_dat_o", 32'(dato2), 32'h0);
    check("rst_ack_i4", 32'(ack4), 32'h0);
`ifdef HS_ARB_PIPE_TAG_EN
    check("rst_tag_o", 32'(tago2), 32'h0);
`endif
    rst = 1'b0;

    // Test 1: single word latency, sender raises req in cycle 0
    pq0.push_back(8'hA5);
    tick(); check("t1_c0_ack", 32'(ack2), 32'h0);
    tick(); check("t1_c1_ack", 32'(ack2), 32'h1);
    tick(); check("t1_c2_ack", 32'(ack2), 32'h0);
            check("t1_c2_req_o", 32'(reqo2), 32'h0);
    tick(); check("t1_c3_req_o", 32'(reqo2), 32'h0);
    tick(); check("t1_c4_req_o", 32'(reqo2), 32'h1);
            check("t1_c4_dat_o", 32'(dato2), 32'hA5);
`ifdef HS_ARB_PIPE_TAG_EN
            check("t1_c4_tag_o", 32'(tago2), 32'h0);
`endif
    tick(); check("t1_c5_req_o", 32'(reqo2), 32'h0);
            check("t1_c5_dat_hold", 32'(dato2), 32'hA5);
    repeat (4) tick();

    // Test 2: simultaneous requests, pointer 0 then pointer 1
    pulse_rst();
    pq0.push_back(8'h11); pq1.push_back(8'h22);
    wait_obs2(2, 40);
    check("t2_gnt0", 32'(gnt2[0]), 32'd0);
    check("t2_gnt1", 32'(gnt2[1]), 32'd1);
    check("t2_out0", 32'(obs2[0]), 32'h11);
    check("t2_out1", 32'(obs2[1]), 32'h22);
    pq0.push_back(8'h33);
    wait_obs2(3, 40);
    check("t2_out2", 32'(obs2[2]), 32'h33);
    pq0.push_back(8'h55); pq1.push_back(8'h66);
    wait_obs2(5, 40);
    check("t2_gnt3", 32'(gnt2[3]), 32'd1);
    check("t2_out3", 32'(obs2[3]), 32'h66);
    check("t2_out4", 32'(obs2[4]), 32'h55);
    repeat (6) tick();

    // Test 3: consumer stalled, five words offered on ch1
    pulse_rst();
    cons_en = 1'b0;
    for (int i = 0; i < 5; i++) pq1.push_back(8'h51 + 8'(i));
    repeat (25) tick();
    check("t3_req_o", 32'(reqo2), 32'h1);
    check("t3_dat_o", 32'(dato2), 32'h51);
    check("t3_ack_i", 32'(ack2), 32'h0);
    check("t3_word5_blocked", 32'(gnt2.size() <= 4), 32'd1);
    cons_en = 1'b1;
    wait_obs2(5, 100);
    for (int i = 0; i < 5; i++) check("t3_order", 32'(obs2[i]), 32'h51 + 32'(i));
    repeat (10) tick();
    check("t3_no_dup", 32'(obs2.size()), 32'd5);

    // Test 4: reset while presenting with full stages and a held request
    pulse_rst();
    cons_en = 1'b0;
    for (int i = 0; i < 5; i++) pq0.push_back(8'h61 + 8'(i));
    repeat (25) tick();
    check("t4_pre_req_o", 32'(reqo2), 32'h1);
    held = dat2[7:0];
    rst = 1'b1; tick();
    check("t4_rst_req_o", 32'(reqo2), 32'h0);
    check("t4_rst_ack_i", 32'(ack2), 32'h0);
    rst = 1'b0; tick();
    check("t4_regrant", 32'(ack2), 32'h1);
    cons_en = 1'b1;
    wait_obs2(1, 40);
    check("t4_first_out", 32'(obs2[0]), 32'(held));
    repeat (60) tick();

    // Test 5: four channels requesting continuously, data = channel id
    for (int c = 0; c < 4; c++) cnt4[c] = 3;
    for (int t = 0; t < 300 && obs4.size() < 12; t++) tick();
    check("t5_count", 32'(obs4.size() >= 12), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("t5_seq", 32'(obs4[i]), 32'(i % 4));
`ifdef HS_ARB_PIPE_TAG_EN
      check("t5_tag", 32'(obs4t[i]), 32'(i % 4));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
`default_nettype wire
